// File: rtl/traffic_pkg.sv
// Shared types for the traffic controller: phase states and one-hot {R,Y,G} lamp codes.
package traffic_pkg;

  // Three-bit encoding leaves spare codes so a corrupted register is detectable.
  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'b001,
    MAIN_YELLOW = 3'b011,
    SIDE_GREEN  = 3'b100,
    SIDE_YELLOW = 3'b110
  } state_e;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

endpackage

// File: rtl/ped_sync.sv
// Pedestrian button: two-flop synchroniser followed by a rising-edge detector.
// Only compiled when TRAFFIC_PED_WALK_EN is defined; the base controller has no button path.
`ifdef TRAFFIC_PED_WALK_EN
module ped_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic btn_rise
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = btn_in;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign btn_rise = sync_q & ~prev_q;

endmodule
`endif

// File: rtl/traffic_fsm.sv
// Two-road traffic controller stepped by the phase timer's ctrl strobe (green/red vs yellow).
// Define TRAFFIC_PED_WALK_EN to add pedestrian walk service with an extended side green.
module traffic_fsm
  import traffic_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ctrl,
  input  logic       ped_btn,
  output logic       request,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk
);

  state_e state_q, state_d;
  logic   ctrl_prev_q, ctrl_prev_d;
  logic   fall, rise;

  assign fall = ctrl_prev_q & ~ctrl;
  assign rise = ~ctrl_prev_q & ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= MAIN_GREEN;
      ctrl_prev_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      ctrl_prev_q <= ctrl_prev_d;
    end
  end

  // Greens leave only on a fall, yellows only on a rise; anything else holds.
  always_comb begin
    ctrl_prev_d = ctrl;
    state_d     = state_q;
    main_light  = RED;
    side_light  = RED;
    case (state_q)
      MAIN_GREEN: begin
        main_light = GRN;
        if (fall) state_d = MAIN_YELLOW;
      end
      MAIN_YELLOW: begin
        main_light = YEL;
        if (rise) state_d = SIDE_GREEN;
      end
      SIDE_GREEN: begin
        side_light = GRN;
        if (fall) state_d = SIDE_YELLOW;
      end
      SIDE_YELLOW: begin
        side_light = YEL;
        if (rise) state_d = MAIN_GREEN;
      end
      default: state_d = MAIN_GREEN;
    endcase
  end

`ifdef TRAFFIC_PED_WALK_EN
  logic ped_rise;
  logic to_side, to_main;
  logic ped_pending_q, ped_pending_d;
  logic request_q, request_d;

  assign to_side = (state_q == MAIN_YELLOW) && rise;
  assign to_main = (state_q == SIDE_YELLOW) && rise;

  ped_sync u_ped_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_in   (ped_btn),
    .btn_rise (ped_rise)
  );

  // request moves only on phase entries, which sit right after the timer wraps;
  // a press landing on the consuming cycle counts as already served.
  always_comb begin
    ped_pending_d = ped_pending_q | ped_rise;
    request_d     = request_q;
    if (to_side) begin
      request_d     = ped_pending_q;
      ped_pending_d = 1'b0;
    end else if (to_main) begin
      request_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ped_pending_q <= 1'b0;
      request_q     <= 1'b0;
    end else begin
      ped_pending_q <= ped_pending_d;
      request_q     <= request_d;
    end
  end

  assign request = request_q;
  assign walk    = (state_q == SIDE_GREEN) && request_q;
`else
  logic unused_ped_btn;
  assign unused_ped_btn = ped_btn;
  assign request        = 1'b0;
  assign walk           = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_fsm.sv
// Bench: traffic_fsm looped with a phase timer model; lamp runs are checked against a queue of expected phases.
module tb_traffic_fsm;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;
`ifdef TRAFFIC_PED_WALK_EN
  localparam bit PED = 1'b1;
`else
  localparam bit PED = 1'b0;
`endif

  typedef struct {
    logic [2:0] m;
    logic [2:0] s;
    logic       w;
    logic       r;
    int         len;
  } seg_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ped_btn = 1'b0;
  logic       ctrl;
  logic       request;
  logic       walk;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic [4:0] tcnt;

  int   n_chk = 0;
  int   n_bad = 0;
  int   cur = 0;
  bit   mon_en = 1'b0;
  seg_t expq[$];
  seg_t run;
  int   run_len = 0;

  always #5 clk = ~clk;

  // Phase timer: normal 13 counts (10 green), extended 18 counts (15 green).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tcnt <= 5'd0;
    else tcnt <= (tcnt == (request ? 5'd17 : 5'd12)) ? 5'd0 : tcnt + 5'd1;
  end
  assign ctrl = tcnt < (request ? 5'd15 : 5'd10);

  traffic_fsm dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ctrl       (ctrl),
    .ped_btn    (ped_btn),
    .request    (request),
    .main_light (main_light),
    .side_light (side_light),
    .walk       (walk)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push(input logic [2:0] m, input logic [2:0] s, input logic w, input logic r,
                      input int len);
    seg_t e;
    e.m = m; e.s = s; e.w = w; e.r = r; e.len = len;
    expq.push_back(e);
  endtask

  task automatic goto(input int k);
    repeat (k - cur) @(posedge clk);
    #2;
    cur = k;
  endtask

  task automatic close_run();
    seg_t e;
    n_chk++;
    if (expq.size() == 0) begin
      n_bad++;
      $display("FAIL run_unexpected: got m=%b s=%b w=%b r=%b len=%0d, expected none",
               run.m, run.s, run.w, run.r, run_len);
    end else begin
      e = expq.pop_front();
      if (run.m !== e.m || run.s !== e.s || run.w !== e.w || run.r !== e.r || run_len != e.len) begin
        n_bad++;
        $display("FAIL run: got m=%b s=%b w=%b r=%b len=%0d, expected m=%b s=%b w=%b r=%b len=%0d",
                 run.m, run.s, run.w, run.r, run_len, e.m, e.s, e.w, e.r, e.len);
      end
    end
  endtask

  // Monitor: every lamp-pattern change closes a run and checks it against the next expected phase.
  always @(negedge clk) begin
    if (!mon_en) begin
      run_len = 0;
    end else begin
      n_chk++;
      if (main_light != R && side_light != R) begin
        n_bad++;
        $display("FAIL overlap: got main=%b side=%b, expected one red", main_light, side_light);
      end
      if (run_len == 0) begin
        run.m = main_light; run.s = side_light; run.w = walk; run.r = request; run_len = 1;
      end else if (run.m === main_light && run.s === side_light && run.w === walk && run.r === request) begin
        run_len++;
      end else begin
        close_run();
        run.m = main_light; run.s = side_light; run.w = walk; run.r = request; run_len = 1;
      end
    end
  end

  initial begin
    #12;
    chk("reset_main", main_light, G);
    chk("reset_side", side_light, R);
    chk("reset_walk", walk, 0);
    chk("reset_request", request, 0);

    push(G, R, 0, 0, 11);
    if (PED) begin
      push(Y, R, 0, 0, 3);  push(R, G, 0, 0, 10); push(R, Y, 0, 0, 3);  push(G, R, 0, 0, 10);
      push(Y, R, 0, 0, 3);  push(R, G, 1, 1, 15); push(R, Y, 0, 1, 3);  push(G, R, 0, 0, 10);
      push(Y, R, 0, 0, 3);  push(R, G, 1, 1, 15); push(R, Y, 0, 1, 3);  push(G, R, 0, 0, 10);
      push(Y, R, 0, 0, 3);  push(R, G, 0, 0, 10); push(R, Y, 0, 0, 3);  push(G, R, 0, 0, 10);
      push(Y, R, 0, 0, 3);
    end else begin
      repeat (4) begin
        push(Y, R, 0, 0, 3); push(R, G, 0, 0, 10); push(R, Y, 0, 0, 3); push(G, R, 0, 0, 10);
      end
      push(Y, R, 0, 0, 3); push(R, G, 0, 0, 10); push(R, Y, 0, 0, 3);
    end

    @(posedge clk);
    #2;
    rst_n = 1'b1;
    mon_en = 1'b1;
    cur = 0;

    // ctrl edges of the wrong kind for the current phase must be ignored
    goto(3);
    force dut.ctrl_prev_q = 1'b0;
    goto(4);
    release dut.ctrl_prev_q;
    goto(11);
    force dut.ctrl_prev_q = 1'b1;
    goto(12);
    release dut.ctrl_prev_q;

    goto(30);  ped_btn = 1'b1;
    goto(32);  ped_btn = 1'b0;
    goto(33);  ped_btn = 1'b1;
    goto(35);  ped_btn = 1'b0;
    goto(45);  ped_btn = 1'b1;
    goto(47);  ped_btn = 1'b0;
    goto(118); ped_btn = 1'b1;
    goto(120); ped_btn = 1'b0;
    goto(132); ped_btn = 1'b1;
    goto(134); ped_btn = 1'b0;

    goto(135);
    chk("pre_reset_walk", walk, PED);
    chk("pre_reset_request", request, PED);
    mon_en = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset_main", main_light, G);
    chk("async_reset_side", side_light, R);
    chk("async_reset_walk", walk, 0);
    chk("async_reset_request", request, 0);

    push(G, R, 0, 0, 11); push(Y, R, 0, 0, 3); push(R, G, 0, 0, 10); push(R, Y, 0, 0, 3);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    mon_en = 1'b1;
    cur = 0;
    goto(30);
    mon_en = 1'b0;
    chk("expected_runs_left", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/traffic_fsm.md
TRAFFIC_FSM -- requirements
Module: traffic_fsm

Interface
REQ-001 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port ctrl  input  1  phase strobe from the phase timer: 1 = green/red phase, 0 = yellow phase.
REQ-004 SHALL have port ped_btn  input  1  raw pedestrian push-button, asynchronous to clk, active-high.
REQ-005 SHALL have port request  output  1  registered; 1 commands the phase timer to the extended period (18 counts, 15 green), 0 to normal (13 counts, 10 green).
REQ-006 SHALL have port main_light  output  3  one-hot {R,Y,G} for the main road.
REQ-007 SHALL have port side_light  output  3  one-hot {R,Y,G} for the side road.
REQ-008 SHALL have port walk  output  1  pedestrian walk lamp across the main road.

Function
REQ-009 SHALL implement states MAIN_GREEN, MAIN_YELLOW, SIDE_GREEN, SIDE_YELLOW.
REQ-010 SHALL register ctrl into ctrl_d each cycle; fall = ctrl_d & ~ctrl; rise = ~ctrl_d & ctrl.
REQ-011 SHALL transition on fall: MAIN_GREEN->MAIN_YELLOW and SIDE_GREEN->SIDE_YELLOW; on rise: MAIN_YELLOW->SIDE_GREEN and SIDE_YELLOW->MAIN_GREEN; otherwise hold.
REQ-012 SHALL ignore fall in YELLOW states and rise in GREEN states (no transition).
REQ-013 SHALL decode lights from state only (Moore): MAIN_GREEN main=G side=R; MAIN_YELLOW main=Y side=R; SIDE_GREEN main=R side=G; SIDE_YELLOW main=R side=Y.
REQ-014 SHALL never drive main and side non-red in the same cycle.
REQ-015 SHALL map any unreachable state encoding to MAIN_GREEN on the next clock.
REQ-016 SHALL synchronise ped_btn through 2 flops, then detect its rising edge; an edge sets ped_pending.
REQ-017 SHALL, on the MAIN_YELLOW->SIDE_GREEN transition, load request <= ped_pending and clear ped_pending in the same cycle.
REQ-018 SHALL, on the SIDE_YELLOW->MAIN_GREEN transition, clear request to 0.
REQ-019 SHALL change request only at the two transitions above, so the timer's period changes only right after its wrap.
REQ-020 SHALL drive walk = 1 only in SIDE_GREEN with request = 1.
REQ-021 SHALL, when a button edge coincides with consumption of ped_pending, treat the press as served (pending ends 0).
REQ-022 SHALL latch presses made while request = 1 and serve them at the next SIDE_GREEN entry.
REQ-023 SHALL treat multiple presses before service as a single request.

Reset
REQ-024 SHALL on rst_n low asynchronously force: state = MAIN_GREEN, ctrl_d = 1, ped_pending = 0, request = 0, sync flops = 0, walk = 0, main_light = G, side_light = R.
REQ-025 SHALL, on reset mid-phase, restart at MAIN_GREEN regardless of prior state and drop any pending press.

Configuration
REQ-026 SHALL support macro TRAFFIC_PED_WALK_EN: when defined, REQ-016..REQ-023 apply.
REQ-027 SHALL, without TRAFFIC_PED_WALK_EN, keep all ports, ignore ped_btn, tie request and walk to 0, and omit the synchroniser.

Structure
REQ-028 SHALL place the state enum and light codes (RED = 3'b100, YEL = 3'b010, GRN = 3'b001) in shared package traffic_pkg.
REQ-029 SHALL implement the 2-flop synchroniser plus edge detector as sub-module ped_sync.

Verification
The bench pairs the DUT with the phase timer (request looped back); cycle 0 is the first clk edge after reset release.
REQ-030 No press, run 60 cycles -> main G 11 cycles, Y 3, then side G 10, side Y 3, main G 10; no overlap.
REQ-031 Press ped_btn 2 cycles during first main green -> request = 1 entering SIDE_GREEN; side G 15 cycles with walk = 1 throughout; side Y 3 cycles; request = 0 entering MAIN_GREEN.
REQ-032 Press during extended side green -> the following side green is again 15 cycles with walk; the current one is not lengthened.
REQ-033 Force ctrl glitches (fall during YELLOW, rise during GREEN) -> state unchanged.
REQ-034 Assert rst_n low in SIDE_GREEN with request = 1 -> outputs reach reset values immediately, asynchronously; pending cleared.
REQ-035 Build without TRAFFIC_PED_WALK_EN, pulse ped_btn -> request and walk stay 0; phases 10/3.
